// File: rtl/parity_arb_pkg.sv
// Shared constants, slot state type and round-robin search for parity_arbiter.
package parity_arb_pkg;

    localparam logic PARITY_MODE_ODD  = 1'b1;
    localparam logic PARITY_MODE_EVEN = 1'b0;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } parity_slot_e;

    // Returns the first set index at or after ptr (wrapping modulo n), or n if none is set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        int unsigned res;
        res = n;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && (res == n) && valid[idx[3:0]]) begin
                res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/parity_arbiter_if.sv
// Requester and response handshake bundle for parity_arbiter.
interface parity_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32
);
    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_sel;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_check;

    modport master (
        output req_valid, req_data, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_check
    );

    modport slave (
        input  req_valid, req_data, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_check
    );

endinterface

// File: rtl/parity_unit.sv
// Combinational parity check: odd mode gives XOR-reduction, even mode its inverse.
module parity_unit
    import parity_arb_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] word,
    input  logic          sel,
    output logic          check
);

    assign check = (sel == PARITY_MODE_ODD) ? ^word : ~^word;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter sharing one parity_unit among NUM_REQ requesters, single-entry result slot.
// Optional error counter enabled by defining PARITY_ARB_ERRCNT_EN.
module parity_arbiter
    import parity_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    parity_arbiter_if.slave   bus,
    output logic              busy
`ifdef PARITY_ARB_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    parity_slot_e   state_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] rsp_id_q;
    logic           rsp_check_q;

    int unsigned    pick;
    logic           accept;
    logic           grant;
    logic [IDW-1:0] g_id;
    logic [DW-1:0]  g_word;
    logic           g_sel;
    logic           g_check;

    assign pick   = rr_pick(MAX_REQ'(bus.req_valid), 32'(ptr_q), NUM_REQ);
    assign accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
    // Reset gating keeps req_ready low even before the slot state is initialised.
    assign grant  = rst_n && accept && (pick < NUM_REQ);
    assign g_id   = IDW'(pick);

    assign bus.req_ready = grant ? (NUM_REQ'(1) << g_id) : '0;

    always_comb begin
        g_word = '0;
        g_sel  = PARITY_MODE_EVEN;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (IDW'(i) == g_id) begin
                g_word = bus.req_data[i*DW +: DW];
                g_sel  = bus.req_sel[i];
            end
        end
    end

    parity_unit #(
        .DW (DW)
    ) u_parity_unit (
        .word  (g_word),
        .sel   (g_sel),
        .check (g_check)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SLOT_EMPTY;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_check_q <= 1'b0;
        end else begin
            unique case (state_q)
                SLOT_EMPTY: begin
                    if (grant) begin
                        state_q <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (bus.rsp_ready && !grant) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
            if (grant) begin
                rsp_id_q    <= g_id;
                rsp_check_q <= g_check;
                ptr_q       <= (g_id == IDW'(NUM_REQ - 1)) ? '0 : g_id + IDW'(1);
            end
        end
    end

    assign bus.rsp_valid = (state_q == SLOT_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_check = rsp_check_q;
    assign busy          = (state_q == SLOT_FULL);

`ifdef PARITY_ARB_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready && !bus.rsp_check && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter: directed stimulus pushes expected responses, monitor pops.
module tb_parity_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 32;

    typedef struct packed {
        logic [1:0] id;
        logic       chk;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy;
`ifdef PARITY_ARB_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int   checks;
    int   errors;
    int   exp_err;
    exp_t exp_q[$];

    parity_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bif ();

    parity_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif.slave),
        .busy    (busy)
`ifdef PARITY_ARB_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic s);
        bif.req_data[i*32 +: 32] = d;
        bif.req_sel[i]           = s;
    endtask

    task automatic push(input int id, input logic c);
        exp_t e;
        e.id  = 2'(id);
        e.chk = c;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_err = 0;
        end else if (bif.rsp_valid && bif.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d check %0b expected none at %0t",
                         bif.rsp_id, bif.rsp_check, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(bif.rsp_id), 32'(e.id));
                chk("rsp_check", 32'(bif.rsp_check), 32'(e.chk));
                if (!e.chk) exp_err++;
            end
        end
    end

    initial begin
        int   ord[4];
        logic zc[4];
        ord = '{3, 0, 1, 2};
        zc  = '{1'b0, 1'b0, 1'b0, 1'b1};
        checks  = 0;
        errors  = 0;
        exp_err = 0;

        // Reset with every requester valid
        rst_n         = 1'b0;
        bif.rsp_ready = 1'b0;
        bif.req_valid = 4'b1111;
        set_req(0, 32'h0000_0001, 1'b1);   // check 1
        set_req(1, 32'h0000_0003, 1'b1);   // check 0
        set_req(2, 32'h0000_0007, 1'b0);   // check 0
        set_req(3, 32'h0000_0000, 1'b0);   // check 1
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bif.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(bif.rsp_id), 32'h0);
        chk("rst_rsp_check", 32'(bif.rsp_check), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        next_cycle();
        rst_n         = 1'b1;
        bif.rsp_ready = 1'b1;

        // Full rotation, one response per cycle
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rot_req_ready", 32'(bif.req_ready), 32'(1 << (k % 4)));
            push(k % 4, ((k % 4) == 0) || ((k % 4) == 3));
            next_cycle();
        end
        bif.req_valid = '0;
        @(negedge clk);
        chk("drain_req_ready", 32'(bif.req_ready), 32'h0);
        next_cycle();

        // Single requester 2
        bif.req_valid = 4'b0100;
        set_req(2, 32'h0000_0007, 1'b1);
        @(negedge clk);
        chk("r2_req_ready", 32'(bif.req_ready), 32'h4);
        push(2, 1'b1);
        next_cycle();
        bif.req_valid = '0;
        @(negedge clk);
        next_cycle();

        // Backpressure on a req-1 result, second req-1 word waiting
        bif.rsp_ready = 1'b0;
        bif.req_valid = 4'b0010;
        set_req(1, 32'h0000_0003, 1'b0);
        @(negedge clk);
        chk("bp_req_ready", 32'(bif.req_ready), 32'h2);
        push(1, 1'b1);
        next_cycle();
        set_req(1, 32'h0000_0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_ready", 32'(bif.req_ready), 32'h0);
            chk("bp_hold_valid", 32'(bif.rsp_valid), 32'h1);
            chk("bp_hold_id", 32'(bif.rsp_id), 32'h1);
            chk("bp_hold_check", 32'(bif.rsp_check), 32'h1);
            next_cycle();
        end
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(bif.req_ready), 32'h2);
        push(1, 1'b0);
        next_cycle();
        bif.req_valid = '0;
        @(negedge clk);
        next_cycle();

        // Pointer wrap after granting req 3
        bif.req_valid = 4'b1000;
        set_req(3, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("wrap_r3_ready", 32'(bif.req_ready), 32'h8);
        push(3, 1'b0);
        next_cycle();
        bif.req_valid = 4'b1001;
        set_req(0, 32'h0000_0001, 1'b1);
        @(negedge clk);
        chk("wrap_r0_ready", 32'(bif.req_ready), 32'h1);
        push(0, 1'b1);
        next_cycle();
        bif.req_valid = '0;
        @(negedge clk);
        next_cycle();

        // Reset while a result is pending: it is discarded and ptr returns to 0
        bif.rsp_ready = 1'b0;
        bif.req_valid = 4'b0100;
        set_req(2, 32'h0000_0005, 1'b0);
        @(negedge clk);
        chk("mid_grant_ready", 32'(bif.req_ready), 32'h4);
        next_cycle();
        bif.req_valid = '0;
        @(negedge clk);
        chk("mid_pending_valid", 32'(bif.rsp_valid), 32'h1);
        next_cycle();
        rst_n         = 1'b0;
        bif.rsp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bif.req_ready), 32'h0);
        next_cycle();
        rst_n         = 1'b1;
        bif.req_valid = 4'b1100;
        set_req(2, 32'h0000_0007, 1'b1);
        set_req(3, 32'h0000_0000, 1'b1);
        @(negedge clk);
        chk("mid_after_valid", 32'(bif.rsp_valid), 32'h0);
        chk("mid_ptr0_ready", 32'(bif.req_ready), 32'h4);
        push(2, 1'b1);
        next_cycle();
        bif.req_valid = '0;
        @(negedge clk);
        next_cycle();

        // Three zero-check responses and one one-check response, order 3,0,1,2
        bif.req_valid = 4'b1111;
        set_req(0, 32'h0000_0000, 1'b1);
        set_req(1, 32'h0000_0003, 1'b1);
        set_req(2, 32'h0000_0001, 1'b0);
        set_req(3, 32'h0000_0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("err_seq_ready", 32'(bif.req_ready), 32'(1 << ord[k]));
            push(ord[k], !zc[ord[k]] ? 1'b0 : 1'b1);
            next_cycle();
        end
        bif.req_valid = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("model_err_total", 32'(exp_err), 32'd3);
`ifdef PARITY_ARB_ERRCNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_cnt_rst", 32'(err_cnt), 32'h0);
`endif
        next_cycle();

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
